life_engine: RTL and testbench

- Parameterised Conway Game of Life core that generalises the fixed 16x16 update path.
- Holds the cell grid and accepts cell edits while stopped.
- Advances generations on a rate tick under a run/pause/step FSM.
- Reports generation count and pattern status (extinct, still life, period-2 oscillator), with optional auto-halt.
- Sits between the user-input/cursor logic and the LED driver. The driver reads `grid` directly.

---
 rtl/life_pkg.sv | 30 +++
 rtl/life_engine_if.sv | 23 ++
 rtl/life_next_gen.sv | 25 ++
 rtl/life_engine.sv | 82 ++++++++
 tb/tb_life_engine.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/life_pkg.sv
// life_pkg: shared types, command priority encoding and neighbour counting for the life engine
package life_pkg;

  typedef enum logic [1:0] {EDIT = 2'd0, RUN = 2'd1, PAUSE = 2'd2, HALT = 2'd3} state_t;

  // Lower enum value wins when several command pulses arrive together
  typedef enum logic [2:0] {CMD_CLEAR, CMD_PAUSE, CMD_START, CMD_STEP, CMD_NONE} cmd_t;

  localparam int MAX_DIM = 64;
  localparam int MAX_CELLS = MAX_DIM * MAX_DIM;
  localparam int IDX_W = $clog2(MAX_CELLS);

  // Grid is flattened row-major (bit r*cols+c), matching a packed [rows][cols] array
  function automatic logic [3:0] neighbour_count(input logic [MAX_CELLS-1:0] g, input int rows,
                                                 input int cols, input int r, input int c,
                                                 input logic wrap);
    logic [3:0] n;
    int rr, cc;
    n = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        rr = wrap ? (r + dr + rows) % rows : r + dr;
        cc = wrap ? (c + dc + cols) % cols : c + dc;
        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < rows && cc >= 0 && cc < cols)
          n += 4'(g[IDX_W'(rr * cols + cc)]);
      end
    return n;
  endfunction

endpackage

// File: rtl/life_engine_if.sv
// life_engine_if: command, cell-edit and status bundle between the controller and the engine
interface life_engine_if #(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int GEN_W = 16
) ();
  import life_pkg::*;
  logic tick, cmd_start, cmd_pause, cmd_step, cmd_clear, wr_en, wr_val;
  logic [$clog2(ROWS)-1:0] wr_row;
  logic [$clog2(COLS)-1:0] wr_col;
  logic [ROWS-1:0][COLS-1:0] grid;
  state_t state;
  logic [GEN_W-1:0] gen_count;
  logic extinct, still, osc2;
  modport master (
    output tick, cmd_start, cmd_pause, cmd_step, cmd_clear, wr_en, wr_val, wr_row, wr_col,
    input grid, state, gen_count, extinct, still, osc2
  );
  modport slave (
    input tick, cmd_start, cmd_pause, cmd_step, cmd_clear, wr_en, wr_val, wr_row, wr_col,
    output grid, state, gen_count, extinct, still, osc2
  );
endinterface

// File: rtl/life_next_gen.sv
// life_next_gen: purely combinational one-generation update of the whole grid
module life_next_gen
  import life_pkg::*;
#(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int WRAP = 1
) (
  input  logic [ROWS-1:0][COLS-1:0] grid,
  output logic [ROWS-1:0][COLS-1:0] next_grid
);
  logic [MAX_CELLS-1:0] flat;
  // Widen the grid to the fixed-size vector the shared counter expects
  always_comb begin
    flat = '0;
    flat[ROWS*COLS-1:0] = grid;
  end
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [3:0] n;
      assign n = neighbour_count(flat, ROWS, COLS, r, c, WRAP != 0);
      assign next_grid[r][c] = (n == 4'd3) | (grid[r][c] & (n == 4'd2));
    end
  end
endmodule

// File: rtl/life_engine.sv
// life_engine: Game of Life core with run/pause/step control, generation counter and pattern status
module life_engine
  import life_pkg::*;
#(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int WRAP = 1,
  parameter int GEN_W = 16,
  parameter int AUTO_HALT = 1
) (
  input logic clk,
  input logic reset_n,
  life_engine_if.slave bus
);
  typedef logic [ROWS-1:0][COLS-1:0] grid_t;
  grid_t grid_q, prev_q, next_g;
  state_t state_q, state_d;
  logic [GEN_W-1:0] gen_q;
  logic still_q, osc2_q;
  cmd_t cmd;
  logic editable, commit, wr_ok, same_cur, same_prev, halt_hit;

  life_next_gen #(.ROWS(ROWS), .COLS(COLS), .WRAP(WRAP)) u_next (.grid(grid_q), .next_grid(next_g));

  // Resolve the command pulses by priority and qualify commits and cell writes
  always_comb begin
    cmd = bus.cmd_clear ? CMD_CLEAR : bus.cmd_pause ? CMD_PAUSE :
          bus.cmd_start ? CMD_START : bus.cmd_step ? CMD_STEP : CMD_NONE;
    editable = state_q != RUN;
    commit = (cmd == CMD_STEP && editable) ||
             (state_q == RUN && bus.tick && cmd != CMD_CLEAR && cmd != CMD_PAUSE);
    wr_ok = bus.wr_en && editable && cmd == CMD_NONE &&
            int'(bus.wr_row) < ROWS && int'(bus.wr_col) < COLS;
    same_cur = next_g == grid_q;
    same_prev = next_g == prev_q;
    halt_hit = AUTO_HALT != 0 && commit && (same_cur || same_prev || next_g == '0);
    state_d = cmd == CMD_CLEAR ? EDIT :
              halt_hit ? HALT :
              cmd == CMD_PAUSE && state_q == RUN ? PAUSE :
              cmd == CMD_START ? RUN :
              cmd == CMD_STEP && editable ? PAUSE : state_q;
  end

  // Control state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= EDIT;
    else state_q <= state_d;

  // Grid, history, generation counter and status flags
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      grid_q <= '0;
      prev_q <= '0;
      gen_q <= '0;
      still_q <= 1'b0;
      osc2_q <= 1'b0;
    end else if (cmd == CMD_CLEAR) begin
      grid_q <= '0;
      prev_q <= '0;
      gen_q <= '0;
      still_q <= 1'b0;
      osc2_q <= 1'b0;
    end else if (commit) begin
      prev_q <= grid_q;
      grid_q <= next_g;
      gen_q <= gen_q == '1 ? gen_q : gen_q + 1'b1;
      still_q <= same_cur;
      osc2_q <= same_prev & !same_cur;
    end else if (wr_ok) begin
      prev_q <= grid_q;
      grid_q[bus.wr_row][bus.wr_col] <= bus.wr_val;
      still_q <= 1'b0;
      osc2_q <= 1'b0;
    end

  assign bus.grid = grid_q;
  assign bus.state = state_q;
  assign bus.gen_count = gen_q;
  assign bus.extinct = grid_q == '0;
  assign bus.still = still_q;
  assign bus.osc2 = osc2_q;
endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: table-driven scoreboard bench for two life_engine configurations
module tb_life_engine;
  import life_pkg::*;

  typedef logic [15:0][15:0] grid_t;
  typedef enum {OP_WR, OP_START, OP_PAUSE, OP_STEP, OP_CLEAR, OP_TICK, OP_PS, OP_CS, OP_IDLE} op_e;
  typedef struct {
    int u; op_e op; int a; int b; int n;
    int pat; int st; int gen; int ext; int stl; int osc;
  } vec_t;
  typedef struct { int id; vec_t v; } sb_t;

  localparam int P_EMPTY = 0, P_BV = 1, P_BH = 2, P_BLOCK = 3, P_GL = 4, P_G5 = 5;

  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  vec_t vecs[$];
  sb_t sb[$];

  logic d_tick[2], d_start[2], d_pause[2], d_step[2], d_clear[2], d_wr[2], d_val[2];
  logic [3:0] d_row[2], d_col[2];

  life_engine_if #(.ROWS(16), .COLS(16), .GEN_W(16)) ia ();
  life_engine_if #(.ROWS(16), .COLS(16), .GEN_W(4)) ib ();

  assign ia.tick = d_tick[0];
  assign ia.cmd_start = d_start[0];
  assign ia.cmd_pause = d_pause[0];
  assign ia.cmd_step = d_step[0];
  assign ia.cmd_clear = d_clear[0];
  assign ia.wr_en = d_wr[0];
  assign ia.wr_val = d_val[0];
  assign ia.wr_row = d_row[0];
  assign ia.wr_col = d_col[0];
  assign ib.tick = d_tick[1];
  assign ib.cmd_start = d_start[1];
  assign ib.cmd_pause = d_pause[1];
  assign ib.cmd_step = d_step[1];
  assign ib.cmd_clear = d_clear[1];
  assign ib.wr_en = d_wr[1];
  assign ib.wr_val = d_val[1];
  assign ib.wr_row = d_row[1];
  assign ib.wr_col = d_col[1];

  life_engine #(.ROWS(16), .COLS(16), .WRAP(1), .GEN_W(16), .AUTO_HALT(0)) u_a (
    .clk(clk), .reset_n(reset_n), .bus(ia));
  life_engine #(.ROWS(16), .COLS(16), .WRAP(0), .GEN_W(4), .AUTO_HALT(1)) u_b (
    .clk(clk), .reset_n(reset_n), .bus(ib));

  function automatic grid_t pat(input int id);
    grid_t g;
    int o;
    g = '0;
    o = id == P_G5 ? 5 : 0;
    case (id)
      P_BV: begin g[7][8] = 1'b1; g[8][8] = 1'b1; g[9][8] = 1'b1; end
      P_BH: begin g[8][7] = 1'b1; g[8][8] = 1'b1; g[8][9] = 1'b1; end
      P_BLOCK: begin g[4][4] = 1'b1; g[4][5] = 1'b1; g[5][4] = 1'b1; g[5][5] = 1'b1; end
      P_GL, P_G5: begin
        g[o][o+1] = 1'b1; g[o+1][o+2] = 1'b1;
        g[o+2][o] = 1'b1; g[o+2][o+1] = 1'b1; g[o+2][o+2] = 1'b1;
      end
      default: ;
    endcase
    return g;
  endfunction

  task automatic clr_all();
    for (int i = 0; i < 2; i++) begin
      d_tick[i] = 1'b0; d_start[i] = 1'b0; d_pause[i] = 1'b0; d_step[i] = 1'b0;
      d_clear[i] = 1'b0; d_wr[i] = 1'b0; d_val[i] = 1'b0; d_row[i] = '0; d_col[i] = '0;
    end
  endtask

  task automatic cmp(input string nm, input int act, input int req);
    if (req < 0) return;
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic cmp_grid(input string nm, input grid_t act, input grid_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, req);
    end
  endtask

  function automatic void add(input int u, input op_e op, input int a, input int b, input int n,
                              input int p, input int st, input int gen, input int ext,
                              input int stl, input int osc);
    vecs.push_back('{u, op, a, b, n, p, st, gen, ext, stl, osc});
  endfunction

  task automatic apply(input int id, input vec_t v);
    int cyc;
    cyc = (v.op == OP_TICK || v.op == OP_IDLE) ? v.n : 1;
    for (int k = 0; k < cyc; k++) begin
      @(negedge clk);
      clr_all();
      case (v.op)
        OP_WR: begin
          d_wr[v.u] = 1'b1; d_row[v.u] = 4'(v.a); d_col[v.u] = 4'(v.b); d_val[v.u] = 1'(v.n);
        end
        OP_START: d_start[v.u] = 1'b1;
        OP_PAUSE: d_pause[v.u] = 1'b1;
        OP_STEP: d_step[v.u] = 1'b1;
        OP_CLEAR: d_clear[v.u] = 1'b1;
        OP_TICK: d_tick[v.u] = 1'b1;
        OP_PS: begin d_pause[v.u] = 1'b1; d_start[v.u] = 1'b1; end
        OP_CS: begin d_clear[v.u] = 1'b1; d_step[v.u] = 1'b1; end
        default: ;
      endcase
      if (k == cyc - 1) sb.push_back('{id, v});
    end
    @(negedge clk);
    clr_all();
  endtask

  // Scoreboard consumer: compares each expectation one step after its edge
  initial forever begin
    sb_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.v.pat >= 0)
        cmp_grid($sformatf("v%0d.grid", e.id), e.v.u != 0 ? ib.grid : ia.grid, pat(e.v.pat));
      cmp($sformatf("v%0d.state", e.id), e.v.u != 0 ? int'(ib.state) : int'(ia.state), e.v.st);
      cmp($sformatf("v%0d.gen", e.id), e.v.u != 0 ? int'(ib.gen_count) : int'(ia.gen_count), e.v.gen);
      cmp($sformatf("v%0d.extinct", e.id), e.v.u != 0 ? int'(ib.extinct) : int'(ia.extinct), e.v.ext);
      cmp($sformatf("v%0d.still", e.id), e.v.u != 0 ? int'(ib.still) : int'(ia.still), e.v.stl);
      cmp($sformatf("v%0d.osc2", e.id), e.v.u != 0 ? int'(ib.osc2) : int'(ia.osc2), e.v.osc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_all();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    // unit A: 16x16 torus, no auto-halt, 16-bit counter
    add(0, OP_IDLE, 0, 0, 1, P_EMPTY, 0, 0, 1, 0, 0);
    add(0, OP_WR, 7, 8, 1, -1, 0, 0, 0, 0, 0);
    add(0, OP_WR, 8, 8, 1, -1, 0, 0, 0, 0, 0);
    add(0, OP_WR, 9, 8, 1, P_BV, 0, 0, 0, 0, 0);
    add(0, OP_START, 0, 0, 0, P_BV, 1, 0, 0, 0, 0);
    add(0, OP_TICK, 0, 0, 1, P_BH, 1, 1, 0, 0, 0);
    add(0, OP_TICK, 0, 0, 1, P_BV, 1, 2, 0, 0, 1);
    add(0, OP_WR, 0, 0, 1, P_BV, 1, 2, 0, 0, 1);
    add(0, OP_PS, 0, 0, 0, P_BV, 2, 2, 0, 0, 1);
    add(0, OP_STEP, 0, 0, 0, P_BH, 2, 3, 0, 0, 1);
    add(0, OP_CS, 0, 0, 0, P_EMPTY, 0, 0, 1, 0, 0);
    add(0, OP_WR, 0, 1, 1, -1, 0, 0, 0, 0, 0);
    add(0, OP_WR, 1, 2, 1, -1, 0, 0, 0, 0, 0);
    add(0, OP_WR, 2, 0, 1, -1, 0, 0, 0, 0, 0);
    add(0, OP_WR, 2, 1, 1, -1, 0, 0, 0, 0, 0);
    add(0, OP_WR, 2, 2, 1, P_GL, 0, 0, 0, 0, 0);
    add(0, OP_START, 0, 0, 0, P_GL, 1, 0, 0, 0, 0);
    add(0, OP_TICK, 0, 0, 64, P_GL, 1, 64, 0, 0, 0);
    // unit B: 16x16 bounded, auto-halt, 4-bit counter
    add(1, OP_IDLE, 0, 0, 1, P_EMPTY, 0, 0, 1, 0, 0);
    add(1, OP_WR, 4, 4, 1, -1, 0, 0, 0, 0, 0);
    add(1, OP_WR, 4, 5, 1, -1, 0, 0, 0, 0, 0);
    add(1, OP_WR, 5, 4, 1, -1, 0, 0, 0, 0, 0);
    add(1, OP_WR, 5, 5, 1, P_BLOCK, 0, 0, 0, 0, 0);
    add(1, OP_STEP, 0, 0, 0, P_BLOCK, 3, 1, 0, 1, 0);
    add(1, OP_TICK, 0, 0, 3, P_BLOCK, 3, 1, 0, 1, 0);
    add(1, OP_CLEAR, 0, 0, 0, P_EMPTY, 0, 0, 1, 0, 0);
    add(1, OP_WR, 0, 0, 1, -1, 0, 0, 0, 0, 0);
    add(1, OP_WR, 0, 15, 1, -1, 0, 0, 0, 0, 0);
    add(1, OP_WR, 15, 0, 1, -1, 0, 0, 0, 0, 0);
    add(1, OP_STEP, 0, 0, 0, P_EMPTY, 3, 1, 1, 0, 0);
    add(1, OP_CLEAR, 0, 0, 0, P_EMPTY, 0, 0, 1, 0, 0);
    add(1, OP_WR, 0, 1, 1, -1, 0, 0, 0, 0, 0);
    add(1, OP_WR, 1, 2, 1, -1, 0, 0, 0, 0, 0);
    add(1, OP_WR, 2, 0, 1, -1, 0, 0, 0, 0, 0);
    add(1, OP_WR, 2, 1, 1, -1, 0, 0, 0, 0, 0);
    add(1, OP_WR, 2, 2, 1, P_GL, 0, 0, 0, 0, 0);
    add(1, OP_START, 0, 0, 0, P_GL, 1, 0, 0, 0, 0);
    add(1, OP_TICK, 0, 0, 20, P_G5, 1, 15, 0, 0, 0);
    foreach (vecs[i]) apply(i, vecs[i]);
    // asynchronous reset in the middle of a cycle while both units run
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    cmp_grid("rst.a.grid", ia.grid, pat(P_EMPTY));
    cmp("rst.a.state", int'(ia.state), 0);
    cmp("rst.a.gen", int'(ia.gen_count), 0);
    cmp("rst.a.extinct", int'(ia.extinct), 1);
    cmp_grid("rst.b.grid", ib.grid, pat(P_EMPTY));
    cmp("rst.b.state", int'(ib.state), 0);
    cmp("rst.b.gen", int'(ib.gen_count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
